mycpu_div_unit: RTL and testbench

Parametrised iterative radix-2 divider for the EXE stage. It executes DIV/DIVU-class operations over several cycles. It uses the same valid/allowin handshake as the pipeline stages, so the EXE stage can hold es_ready_go low until the result returns. It carries an opaque tag (dest/PC bits) alongside each operation and supports flush for squashing wrong-path work.

---
 rtl/mycpu_div_unit.sv | 143 ++++++++++++++
 tb/tb_mycpu_div_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mycpu_div_unit.sv
// mycpu_div_unit: iterative radix-2 restoring divider for the EXE stage.
// Signed (DIV) and unsigned (DIVU) operations. Uses the pipeline valid/allowin
// handshake, carries an opaque tag alongside each operation, and supports
// flush for squashing wrong-path work.
// Optional feature macro: DIV_EARLY_OUT_EN. When it is defined, divide-by-zero
// and |dividend| < |divisor| finish directly at the accepting edge.
module mycpu_div_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_q, state_d, accept_st;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q;      // partial remainder (always < divisor)
  logic [WIDTH-1:0]   quo_q;      // shifts dividend out, quotient bits in
  logic [WIDTH-1:0]   dvs_q;      // divisor magnitude
  logic [WIDTH-1:0]   dvd_raw_q;  // original dividend pattern for /0
  logic               neg_quo_q, neg_rem_q, dz_q;
  logic [TAG_W-1:0]   tag_q;

  logic               accept;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     partial, diff;
  logic               no_borrow;
  logic [WIDTH-1:0]   fix_quo, fix_rem;

  // Operand decode: magnitudes and signs of the offered operation.
  assign accept = in_valid && in_ready && !flush;
  assign sign_a = signed_op & dividend[WIDTH-1];
  assign sign_b = signed_op & divisor[WIDTH-1];
  assign mag_a  = sign_a ? -dividend : dividend;
  assign mag_b  = sign_b ? -divisor  : divisor;

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
  assign partial   = {rem_q, quo_q[WIDTH-1]};
  assign diff      = partial - {1'b0, dvs_q};
  assign no_borrow = !diff[WIDTH];

  // Final result correction; divide-by-zero overrides the sign fix.
  assign fix_quo = dz_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
  assign fix_rem = dz_q ? dvd_raw_q : (neg_rem_q ? -rem_q : rem_q);

  // Destination state for an accepted operation.
  always_comb begin
    accept_st = BUSY;
`ifdef DIV_EARLY_OUT_EN
    if ((divisor == '0) || (mag_a < mag_b)) accept_st = DONE;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of the order the blocks are evaluated in.
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; flush overrides everything below reset.
  always_comb begin
    // NOTE: the default assignment up front keeps this block free of latches
    // on every path through the case.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = accept_st;
      BUSY:    if (cnt_q == CNT_W'(1)) state_d = FIXUP;
      FIXUP:   state_d = DONE;
      DONE:    if (out_ready) state_d = accept ? accept_st : IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Handshake outputs.
  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    out_valid = (state_q == DONE);
  end

  // Datapath: operand capture, iteration, and result registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      dvd_raw_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      tag_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      out_tag   <= '0;
    end else if (accept) begin
      cnt_q     <= CNT_W'(WIDTH);
      rem_q     <= '0;
      quo_q     <= mag_a;
      dvs_q     <= mag_b;
      dvd_raw_q <= dividend;
      neg_quo_q <= sign_a ^ sign_b;
      neg_rem_q <= sign_a;
      dz_q      <= (divisor == '0);
      tag_q     <= in_tag;
`ifdef DIV_EARLY_OUT_EN
      if (accept_st == DONE) begin
        quotient  <= (divisor == '0) ? '1 : '0;
        remainder <= dividend;
        out_tag   <= in_tag;
      end
`endif
    end else if (!flush && state_q == BUSY) begin
      cnt_q <= cnt_q - CNT_W'(1);
      rem_q <= no_borrow ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
      quo_q <= {quo_q[WIDTH-2:0], no_borrow};
    end else if (!flush && state_q == FIXUP) begin
      quotient  <= fix_quo;
      remainder <= fix_rem;
      out_tag   <= tag_q;
    end
  end

endmodule

// File: tb/tb_mycpu_div_unit.sv
// tb_mycpu_div_unit: directed vectors for mycpu_div_unit (WIDTH=32, TAG_W=5)
// plus hand-written sequences for backpressure, flush and mid-operation reset.
// Latency is counted in rising edges after the accepting edge: 33 for the full
// path, 0 for an early-out (result visible in the cycle after accept).
module tb_mycpu_div_unit;

  localparam int W        = 32;
  localparam int TW       = 5;
  localparam int LAT_FULL = 33;
  localparam int LAT_EARLY = 0;
  localparam int WAIT_MAX = 60;

  logic          clk, resetn, flush, in_valid, in_ready, signed_op;
  logic [W-1:0]  dividend, divisor, quotient, remainder;
  logic [TW-1:0] in_tag, out_tag;
  logic          out_valid, out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  mycpu_div_unit #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .signed_op (signed_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          s;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [TW-1:0] tag;
    logic [W-1:0]  q;
    logic [W-1:0]  r;
    logic          early;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one operation and return just after the accepting edge.
  task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TW-1:0] tag);
    int n = 0;
    signed_op = s; dividend = a; divisor = b; in_tag = tag; in_valid = 1'b1;
    while (!in_ready && n < WAIT_MAX) begin step(); n++; end
    check("in_ready_at_offer", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < WAIT_MAX) begin step(); n++; end
  endtask

  task automatic check_result(input string name, input int lat_exp,
                              input logic [W-1:0] q, input logic [W-1:0] r,
                              input logic [TW-1:0] tag);
    int n;
    wait_valid(n);
    check({name, "_latency"}, n, lat_exp);
    check({name, "_quotient"}, quotient, q);
    check({name, "_remainder"}, remainder, r);
    check({name, "_tag"}, out_tag, tag);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  n, lat;
    logic seen;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          5'd1,  32'd14,         32'd2,          1'b0};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          5'd2,  32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   5'd3,  32'hFFFFFFFD,   32'd1,          1'b0};
    vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   5'd4,  32'h80000000,   32'd0,          1'b0};
    vecs[4]  = '{1'b0, 32'h12345678,   32'd0,          5'd5,  32'hFFFFFFFF,   32'h12345678,   1'b1};
    vecs[5]  = '{1'b1, 32'h12345678,   32'd0,          5'd6,  32'hFFFFFFFF,   32'h12345678,   1'b1};
    vecs[6]  = '{1'b0, 32'd3,          32'd10,         5'd7,  32'd0,          32'd3,          1'b1};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          5'd8,  32'hFFFFFFFF,   32'd0,          1'b0};
    vecs[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   5'd9,  32'd14,         32'hFFFFFFFE,   1'b0};
    vecs[9]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   5'd10, 32'd0,          32'h80000000,   1'b1};
    vecs[10] = '{1'b1, 32'hFFFFFFFD,   32'd10,         5'd11, 32'd0,          32'hFFFFFFFD,   1'b1};
    vecs[11] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   5'd31, 32'd1,          32'd0,          1'b0};

    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; signed_op = 1'b0;
    dividend = '0; divisor = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) step();
    check("reset_out_valid", out_valid, 0);
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    check("reset_out_tag", out_tag, 0);
    check("reset_in_ready", in_ready, 1);
    resetn = 1'b1;
    step();

    // Table-driven vectors, out_ready held high.
    for (int i = 0; i < 12; i++) begin
`ifdef DIV_EARLY_OUT_EN
      lat = vecs[i].early ? LAT_EARLY : LAT_FULL;
`else
      lat = LAT_FULL;
`endif
      start_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].tag);
      check_result($sformatf("vec%0d", i), lat, vecs[i].q, vecs[i].r, vecs[i].tag);
      step();
    end

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    start_op(1'b0, 32'd100, 32'd7, 5'd9);
    check_result("bp", LAT_FULL, 32'd14, 32'd2, 5'd9);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_quotient", quotient, 14);
      check("bp_hold_remainder", remainder, 2);
      check("bp_hold_tag", out_tag, 9);
      check("bp_hold_in_ready", in_ready, 0);
    end
    // Release with a new op offered in the same cycle: back-to-back accept.
    out_ready = 1'b1;
    signed_op = 1'b0; dividend = 32'd1000; divisor = 32'd10; in_tag = 5'd3; in_valid = 1'b1;
    #1;
    check("b2b_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check_result("b2b", LAT_FULL, 32'd100, 32'd0, 5'd3);
    step();

    // Flush on the 10th BUSY cycle: no result ever appears.
    start_op(1'b0, 32'd500, 32'd3, 5'd4);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_in_ready", in_ready, 1);
    check("flush_out_valid", out_valid, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen |= out_valid;
      step();
    end
    check("flush_no_result", seen, 0);

    // Flush while an op is offered in IDLE: it must be ignored.
    signed_op = 1'b0; dividend = 32'd9; divisor = 32'd3; in_tag = 5'd12;
    in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen |= out_valid;
      step();
    end
    check("flush_ignores_offer", seen, 0);

    // Synchronous reset mid-BUSY clears every output register.
    start_op(1'b0, 32'd100, 32'd7, 5'd2);
    repeat (5) step();
    resetn = 1'b0;
    step();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_out_tag", out_tag, 0);
    resetn = 1'b1;
    step();
    wait_valid(n);
    check("midrst_no_result", out_valid, 0);

    // Recovery after reset.
    start_op(1'b0, 32'd100, 32'd7, 5'd21);
    check_result("recover", LAT_FULL, 32'd14, 32'd2, 5'd21);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
